// File: rtl/cnt_mon.sv
// cnt_mon: receive-side monitor for the loadable counter path.
// Brings the counter value q, carry cy and load strobe ld from the clk_tx
// domain into clk_sys. It counts carry events, checks that accepted q values
// step by +1, and returns snapshots over a level req/ack handshake.
// Optional feature macro: CNT_MON_IRQ_EN (threshold interrupt on irq).
module cnt_mon #(
    parameter int            CW     = 4,
    parameter int            EW     = 8,
    parameter logic [EW-1:0] IRQ_TH = EW'(200)
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic [CW-1:0] q_in,
    input  logic          cy_in,
    input  logic          ld_in,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic [CW-1:0] snap_q,
    output logic [EW-1:0] snap_evt,
    output logic          snap_err,
    output logic          evt_ovf,
    output logic          irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAP  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [CW-1:0] q_s1, q_s2, q_prev, q_acc, q_inc;
    logic          q_valid;
    logic          cy_s1, cy_s2, cy_d;
    logic          ld_s1, ld_s2, ld_pend;
    logic [EW-1:0] evt_cnt;
    logic          err;
    logic [1:0]    state;

    logic q_stable, q_first, q_change, seq_bad, cy_edge, evt_sat, cap;

    // Decode of filter, sequence-check and carry-edge conditions
    always_comb begin
        q_inc    = q_acc + CW'(1);
        q_stable = (q_s2 == q_prev);
        q_first  = q_stable && !q_valid;
        q_change = q_stable && q_valid && (q_s2 != q_acc);
        // A load seen since the last accepted change (or right now) excuses any jump
        seq_bad  = q_change && !(ld_pend || ld_s2) && (q_s2 != q_inc);
        cy_edge  = cy_s2 && !cy_d;
        evt_sat  = &evt_cnt;
        cap      = (state == S_CAP);
    end

    // Two-flop synchronisers plus the one-cycle history used by the filters
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            q_s1   <= '0;
            q_s2   <= '0;
            q_prev <= '0;
            cy_s1  <= 1'b0;
            cy_s2  <= 1'b0;
            cy_d   <= 1'b0;
            ld_s1  <= 1'b0;
            ld_s2  <= 1'b0;
        end else begin
            q_s1   <= q_in;
            q_s2   <= q_s1;
            q_prev <= q_s2;
            cy_s1  <= cy_in;
            cy_s2  <= cy_s1;
            cy_d   <= cy_s2;
            ld_s1  <= ld_in;
            ld_s2  <= ld_s1;
        end
    end

    // Accept q only after two identical synced samples; track pending load
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            q_acc   <= '0;
            q_valid <= 1'b0;
            ld_pend <= 1'b0;
        end else begin
            if (q_first) begin
                q_acc   <= q_s2;
                q_valid <= 1'b1;
            end else if (q_change) begin
                q_acc   <= q_s2;
            end
            if (q_change)
                ld_pend <= 1'b0;
            else if (ld_s2)
                ld_pend <= 1'b1;
        end
    end

    // Event counter, sticky error and overflow; a capture opens a new window
    // that already includes any event detected in the capture cycle
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            evt_cnt <= '0;
            err     <= 1'b0;
            evt_ovf <= 1'b0;
        end else if (cap) begin
            evt_cnt <= cy_edge ? EW'(1) : '0;
            err     <= seq_bad;
            evt_ovf <= 1'b0;
        end else begin
            if (cy_edge && !evt_sat)
                evt_cnt <= evt_cnt + EW'(1);
            if (cy_edge && evt_sat)
                evt_ovf <= 1'b1;
            if (seq_bad)
                err <= 1'b1;
        end
    end

    // Read handshake FSM: IDLE -> CAP (snapshot) -> ACK (hold until req drops)
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rd_ack   <= 1'b0;
            snap_q   <= '0;
            snap_evt <= '0;
            snap_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd_req)
                        state <= S_CAP;
                end
                S_CAP: begin
                    snap_q   <= q_acc;
                    snap_evt <= evt_cnt;
                    snap_err <= err;
                    rd_ack   <= 1'b1;
                    state    <= S_ACK;
                end
                S_ACK: begin
                    if (!rd_req) begin
                        rd_ack <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    rd_ack <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CNT_MON_IRQ_EN
    // Threshold interrupt: set on reaching IRQ_TH or on overflow, cleared by a read
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst)
            irq <= 1'b0;
        else if (cap)
            irq <= 1'b0;
        else if ((evt_cnt >= IRQ_TH) || evt_ovf)
            irq <= 1'b1;
    end
`else
    // Feature disabled: constant output; the threshold only feeds a dead constant
    logic irq_th_unused;
    assign irq_th_unused = ^IRQ_TH;
    assign irq           = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_mon.sv
// Bench for cnt_mon: directed stimulus with a queue-based scoreboard.
// The read task pushes the expected snapshot; a monitor pops it on rd_ack rise.
module tb_cnt_mon;

    logic       clk_sys;
    logic       rst;
    logic [3:0] q_in;
    logic       cy_in;
    logic       ld_in;
    logic       rd_req;
    logic       rd_ack;
    logic [3:0] snap_q;
    logic [7:0] snap_evt;
    logic       snap_err;
    logic       evt_ovf;
    logic       irq;

    cnt_mon #(
        .CW     (4),
        .EW     (8),
        .IRQ_TH (8'd3)
    ) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .q_in     (q_in),
        .cy_in    (cy_in),
        .ld_in    (ld_in),
        .rd_req   (rd_req),
        .rd_ack   (rd_ack),
        .snap_q   (snap_q),
        .snap_evt (snap_evt),
        .snap_err (snap_err),
        .evt_ovf  (evt_ovf),
        .irq      (irq)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [3:0] q;
        logic [7:0] evt;
        logic       err;
    } snap_t;

    snap_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic  ack_prev = 1'b0;

`ifdef CNT_MON_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each presented snapshot against the oldest expectation
    always @(negedge clk_sys) begin
        if (rd_ack && !ack_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                snap_t e;
                e = exp_q.pop_front();
                chk("snap_q", 32'(snap_q), 32'(e.q));
                chk("snap_evt", 32'(snap_evt), 32'(e.evt));
                chk("snap_err", 32'(snap_err), 32'(e.err));
                $display("read: snap_q=%0d snap_evt=%0d snap_err=%0d", snap_q, snap_evt, snap_err);
            end
        end
        ack_prev <= rd_ack;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic set_q(input logic [3:0] v);
        q_in = v;
        step(8);
    endtask

    task automatic pulse_cy(input int hi, input int lo);
        cy_in = 1'b1;
        step(hi);
        cy_in = 1'b0;
        step(lo);
    endtask

    task automatic pulse_ld;
        ld_in = 1'b1;
        step(2);
        ld_in = 1'b0;
        step(4);
    endtask

    // Full handshake; hold keeps rd_req high that many cycles after ack
    task automatic do_read(input logic [3:0] eq, input logic [7:0] ee, input logic er, input int hold);
        snap_t e;
        e.q = eq; e.evt = ee; e.err = er;
        exp_q.push_back(e);
        @(negedge clk_sys);
        rd_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (rd_ack) break;
        end
        chk("ack_rise", 32'(rd_ack), 32'd1);
        if (hold > 0) begin
            step(hold);
            chk("ack_held", 32'(rd_ack), 32'd1);
        end
        rd_req = 1'b0;
        @(negedge clk_sys);
        chk("ack_drop", 32'(rd_ack), 32'd0);
        step(2);
    endtask

    initial begin
        rst    = 1'b0;
        rd_req = 1'b0;
        // 1: reset with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            q_in  = 4'($urandom);
            cy_in = 1'($urandom);
            ld_in = 1'($urandom);
        end
        chk("rst_rd_ack", 32'(rd_ack), 32'd0);
        chk("rst_snap_q", 32'(snap_q), 32'd0);
        chk("rst_snap_evt", 32'(snap_evt), 32'd0);
        chk("rst_snap_err", 32'(snap_err), 32'd0);
        chk("rst_evt_ovf", 32'(evt_ovf), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        q_in  = 4'd0;
        cy_in = 1'b0;
        ld_in = 1'b0;
        step(2);
        rst = 1'b1;
        step(10);
        do_read(4'd0, 8'd0, 1'b0, 0);

        // 2: count 1..15 then wrap to 0 with one carry pulse
        for (int v = 1; v < 16; v++) set_q(4'(v));
        q_in = 4'd0;
        pulse_cy(3, 5);
        step(4);
        do_read(4'd0, 8'd1, 1'b0, 0);

        // 3: jump without load -> error; with loads -> clean
        pulse_ld();
        set_q(4'd5);
        set_q(4'd9);
        do_read(4'd9, 8'd0, 1'b1, 0);
        pulse_ld();
        set_q(4'd5);
        pulse_ld();
        set_q(4'd9);
        do_read(4'd9, 8'd0, 1'b0, 0);

        // 4: saturation after 260 pulses
        for (int i = 0; i < 260; i++) pulse_cy(2, 2);
        step(4);
        chk("ovf_set", 32'(evt_ovf), 32'd1);
        chk("irq_sat", 32'(irq), 32'(IRQ_ON));
        do_read(4'd9, 8'd255, 1'b0, 0);
        chk("ovf_clr", 32'(evt_ovf), 32'd0);
        chk("irq_clr_sat", 32'(irq), 32'd0);
        do_read(4'd9, 8'd0, 1'b0, 0);

        // 5: carry edge lands in the capture cycle; rd_ack held while rd_req high
        @(negedge clk_sys);
        cy_in = 1'b1;
        do_read(4'd9, 8'd0, 1'b0, 5);
        cy_in = 1'b0;
        step(4);
        do_read(4'd9, 8'd1, 1'b0, 0);

        // 6: threshold interrupt at 3 events
        chk("irq_before", 32'(irq), 32'd0);
        for (int i = 0; i < 3; i++) pulse_cy(2, 3);
        step(4);
        chk("irq_th", 32'(irq), 32'(IRQ_ON));
        do_read(4'd9, 8'd3, 1'b0, 0);
        chk("irq_after_read", 32'(irq), 32'd0);

        step(5);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
